// File: rtl/mat_accum_arb.sv
// Two-requester round-robin arbiter for a shared 3x3 matrix accumulator: 1-cycle grant, then FEED/DRAIN pass-through with
// combinational valid/ready gated by i_clk_e; optional framing-error flag under `MAT_ACCUM_ARB_ERR_EN.
module mat_accum_arb #(
  parameter int FEED_BEATS = 27,
  parameter int RES_BEATS  = 9
) (
  input  logic              i_clk,
  input  logic              i_clk_e,
  input  logic              i_rst_n,
  input  logic signed [7:0] s0_axis_data,
  input  logic              s0_axis_valid,
  output logic              s0_axis_ready,
  input  logic              s0_axis_last,
  input  logic signed [7:0] s1_axis_data,
  input  logic              s1_axis_valid,
  output logic              s1_axis_ready,
  input  logic              s1_axis_last,
  output logic signed [7:0] m_axis_acc_data,
  output logic              m_axis_acc_valid,
  input  logic              m_axis_acc_ready,
  output logic              m_axis_acc_last,
  input  logic signed [7:0] s_axis_res_data,
  input  logic              s_axis_res_valid,
  output logic              s_axis_res_ready,
  input  logic              s_axis_res_last,
  output logic signed [7:0] m0_axis_res_data,
  output logic              m0_axis_res_valid,
  input  logic              m0_axis_res_ready,
  output logic              m0_axis_res_last,
  output logic signed [7:0] m1_axis_res_data,
  output logic              m1_axis_res_valid,
  input  logic              m1_axis_res_ready,
  output logic              m1_axis_res_last,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic              rr_ptr;
  logic [4:0]        cnt;
  logic              in_feed;
  logic              in_drain;
  logic              own_vld;
  logic signed [7:0] own_dat;
  logic              own_res_rdy;
  logic              feed_beat;
  logic              res_beat;
  logic              feed_end;
  logic              res_end;

  assign in_feed     = (state == ST_FEED);
  assign in_drain    = (state == ST_DRAIN);
  assign own_vld     = owner ? s1_axis_valid : s0_axis_valid;
  assign own_dat     = owner ? s1_axis_data : s0_axis_data;
  assign own_res_rdy = owner ? m1_axis_res_ready : m0_axis_res_ready;
  assign feed_end    = (cnt == 5'(FEED_BEATS - 1));
  assign res_end     = (cnt == 5'(RES_BEATS - 1));
  assign feed_beat   = in_feed & own_vld & m_axis_acc_ready & i_clk_e;
  assign res_beat    = in_drain & s_axis_res_valid & own_res_rdy & i_clk_e;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      cnt    <= '0;
    end else if (i_clk_e) begin
      case (state)
        ST_IDLE: begin
          if (s0_axis_valid | s1_axis_valid) begin
            // Contention goes to the pointer; a lone requester wins outright.
            owner <= (s0_axis_valid & s1_axis_valid) ? rr_ptr : s1_axis_valid;
            state <= ST_FEED;
            cnt   <= '0;
          end
        end
        ST_FEED: begin
          if (feed_beat) begin
            if (feed_end) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (res_beat) begin
            if (res_end) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              rr_ptr <= ~owner;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign m_axis_acc_data  = in_feed ? own_dat : '0;
  assign m_axis_acc_valid = in_feed & own_vld & i_clk_e;
  assign m_axis_acc_last  = in_feed & feed_end;
  assign s0_axis_ready    = in_feed & ~owner & m_axis_acc_ready & i_clk_e;
  assign s1_axis_ready    = in_feed & owner & m_axis_acc_ready & i_clk_e;

  // Result last is regenerated from the beat count; the accumulator's own last is not trusted.
  assign s_axis_res_ready  = in_drain & own_res_rdy & i_clk_e;
  assign m0_axis_res_data  = (in_drain & ~owner) ? s_axis_res_data : '0;
  assign m0_axis_res_valid = in_drain & ~owner & s_axis_res_valid & i_clk_e;
  assign m0_axis_res_last  = in_drain & ~owner & res_end;
  assign m1_axis_res_data  = (in_drain & owner) ? s_axis_res_data : '0;
  assign m1_axis_res_valid = in_drain & owner & s_axis_res_valid & i_clk_e;
  assign m1_axis_res_last  = in_drain & owner & res_end;

  assign o_owner = owner;
  assign o_busy  = (state != ST_IDLE);

`ifdef MAT_ACCUM_ARB_ERR_EN
  logic own_last;
  logic err_q;
  logic unused_res_last;

  assign own_last        = owner ? s1_axis_last : s0_axis_last;
  assign unused_res_last = s_axis_res_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (feed_beat && (own_last != feed_end)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic unused_lasts;

  assign unused_lasts = ^{s0_axis_last, s1_axis_last, s_axis_res_last};
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mat_accum_arb.sv
// Directed bench for mat_accum_arb: job-level reference model checked every cycle, plus literal per-scenario expectations.
module tb_mat_accum_arb;

  localparam int FEED = 27;
  localparam int RES  = 9;

  logic              i_clk = 1'b0;
  logic              i_clk_e;
  logic              i_rst_n;
  logic signed [7:0] s0_axis_data, s1_axis_data, s_axis_res_data;
  logic              s0_axis_valid, s0_axis_ready, s0_axis_last;
  logic              s1_axis_valid, s1_axis_ready, s1_axis_last;
  logic signed [7:0] m_axis_acc_data, m0_axis_res_data, m1_axis_res_data;
  logic              m_axis_acc_valid, m_axis_acc_ready, m_axis_acc_last;
  logic              s_axis_res_valid, s_axis_res_ready, s_axis_res_last;
  logic              m0_axis_res_valid, m0_axis_res_ready, m0_axis_res_last;
  logic              m1_axis_res_valid, m1_axis_res_ready, m1_axis_res_last;
  logic              o_owner, o_busy, o_err;

  mat_accum_arb #(.FEED_BEATS(FEED), .RES_BEATS(RES)) dut (
    .i_clk(i_clk), .i_clk_e(i_clk_e), .i_rst_n(i_rst_n),
    .s0_axis_data(s0_axis_data), .s0_axis_valid(s0_axis_valid), .s0_axis_ready(s0_axis_ready), .s0_axis_last(s0_axis_last),
    .s1_axis_data(s1_axis_data), .s1_axis_valid(s1_axis_valid), .s1_axis_ready(s1_axis_ready), .s1_axis_last(s1_axis_last),
    .m_axis_acc_data(m_axis_acc_data), .m_axis_acc_valid(m_axis_acc_valid), .m_axis_acc_ready(m_axis_acc_ready),
    .m_axis_acc_last(m_axis_acc_last),
    .s_axis_res_data(s_axis_res_data), .s_axis_res_valid(s_axis_res_valid), .s_axis_res_ready(s_axis_res_ready),
    .s_axis_res_last(s_axis_res_last),
    .m0_axis_res_data(m0_axis_res_data), .m0_axis_res_valid(m0_axis_res_valid), .m0_axis_res_ready(m0_axis_res_ready),
    .m0_axis_res_last(m0_axis_res_last),
    .m1_axis_res_data(m1_axis_res_data), .m1_axis_res_valid(m1_axis_res_valid), .m1_axis_res_ready(m1_axis_res_ready),
    .m1_axis_res_last(m1_axis_res_last),
    .o_owner(o_owner), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference: a job is owned by one requester, takes FEED beats in, then RES beats out.
  logic md_active, md_owner, md_rr, md_err;
  int   md_fed, md_ret;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      md_active <= 1'b0; md_owner <= 1'b0; md_rr <= 1'b0; md_err <= 1'b0;
      md_fed <= 0; md_ret <= 0;
    end else if (i_clk_e) begin
      if (!md_active) begin
        if (s0_axis_valid || s1_axis_valid) begin
          md_owner  <= (s0_axis_valid && s1_axis_valid) ? md_rr : s1_axis_valid;
          md_active <= 1'b1;
          md_fed    <= 0;
          md_ret    <= 0;
        end
      end else if (md_fed < FEED) begin
        if ((md_owner ? s1_axis_valid : s0_axis_valid) && m_axis_acc_ready) begin
`ifdef MAT_ACCUM_ARB_ERR_EN
          if ((md_owner ? s1_axis_last : s0_axis_last) != (md_fed == FEED - 1)) md_err <= 1'b1;
`endif
          md_fed <= md_fed + 1;
        end
      end else if (s_axis_res_valid && (md_owner ? m1_axis_res_ready : m0_axis_res_ready)) begin
        md_ret <= md_ret + 1;
        if (md_ret == RES - 1) begin
          md_active <= 1'b0;
          md_rr     <= !md_owner;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    logic feeding, draining, ov, omr;
    feeding  = md_active && (md_fed < FEED);
    draining = md_active && (md_fed >= FEED);
    ov       = md_owner ? s1_axis_valid : s0_axis_valid;
    omr      = md_owner ? m1_axis_res_ready : m0_axis_res_ready;
    chk("busy", int'(o_busy), int'(md_active));
    if (md_active) chk("owner", int'(o_owner), int'(md_owner));
    chk("err", int'(o_err), int'(md_err));
    chk("acc_valid", int'(m_axis_acc_valid), int'(feeding && ov && i_clk_e));
    chk("acc_last", int'(m_axis_acc_last), int'(feeding && md_fed == FEED - 1));
    chk("s0_ready", int'(s0_axis_ready), int'(feeding && !md_owner && m_axis_acc_ready && i_clk_e));
    chk("s1_ready", int'(s1_axis_ready), int'(feeding && md_owner && m_axis_acc_ready && i_clk_e));
    chk("res_ready", int'(s_axis_res_ready), int'(draining && omr && i_clk_e));
    chk("m0_valid", int'(m0_axis_res_valid), int'(draining && !md_owner && s_axis_res_valid && i_clk_e));
    chk("m1_valid", int'(m1_axis_res_valid), int'(draining && md_owner && s_axis_res_valid && i_clk_e));
    chk("m0_last", int'(m0_axis_res_last), int'(draining && !md_owner && md_ret == RES - 1));
    chk("m1_last", int'(m1_axis_res_last), int'(draining && md_owner && md_ret == RES - 1));
    if (feeding && ov && i_clk_e)
      chk("acc_data", int'(m_axis_acc_data), int'(md_owner ? s1_axis_data : s0_axis_data));
    if (m0_axis_res_valid) chk("m0_data", int'(m0_axis_res_data), int'(s_axis_res_data));
    if (m1_axis_res_valid) chk("m1_data", int'(m1_axis_res_data), int'(s_axis_res_data));
  end

  // Stimulus state and observation logs, owned by the main initial block.
  int s0_left, s1_left, s0_sent, s1_sent, s0_lpos, s1_lpos, res_left;
  logic signed [7:0] s0_val;
  logic toggle_rdy;
  int acc_beats, acc_lasts, acc_last_beat;
  int m0_rx, m0_sum, m0_last_idx, m1_rx, m1_sum, m1_last_idx;
  int owner_log[$];

  task automatic drive();
    s0_axis_valid   = (s0_left > 0);
    s0_axis_data    = s0_val;
    s0_axis_last    = ((s0_sent % FEED) == s0_lpos);
    s1_axis_valid   = (s1_left > 0);
    s1_axis_data    = 8'(s1_sent + 20);
    s1_axis_last    = ((s1_sent % FEED) == s1_lpos);
    s_axis_res_valid = (res_left > 0);
    s_axis_res_data  = 8'sd3;
    s_axis_res_last  = (res_left == 1);
  endtask

  task automatic clear_logs();
    acc_beats = 0; acc_lasts = 0; acc_last_beat = 0;
    m0_rx = 0; m0_sum = 0; m0_last_idx = 0;
    m1_rx = 0; m1_sum = 0; m1_last_idx = 0;
    owner_log.delete();
  endtask

  task automatic step();
    logic f0, f1, fa, fr, fm0, fm1, la, lm0, lm1, own;
    int d0, d1;
    @(negedge i_clk);
    f0  = s0_axis_valid && s0_axis_ready;
    f1  = s1_axis_valid && s1_axis_ready;
    fa  = m_axis_acc_valid && m_axis_acc_ready;
    la  = m_axis_acc_last;
    fr  = s_axis_res_valid && s_axis_res_ready;
    fm0 = m0_axis_res_valid && m0_axis_res_ready;
    fm1 = m1_axis_res_valid && m1_axis_res_ready;
    lm0 = m0_axis_res_last;
    lm1 = m1_axis_res_last;
    d0  = int'(m0_axis_res_data);
    d1  = int'(m1_axis_res_data);
    own = o_owner;
    @(posedge i_clk);
    #1;
    if (f0) begin s0_left--; s0_sent++; end
    if (f1) begin s1_left--; s1_sent++; end
    if (fa) begin
      acc_beats++;
      if (la) begin
        acc_lasts++;
        acc_last_beat = acc_beats;
        res_left += RES;
        owner_log.push_back(int'(own));
      end
    end
    if (fr) res_left--;
    if (fm0) begin m0_rx++; m0_sum += d0; if (lm0) m0_last_idx = m0_rx; end
    if (fm1) begin m1_rx++; m1_sum += d1; if (lm1) m1_last_idx = m1_rx; end
    if (toggle_rdy) begin
      m_axis_acc_ready  = ~m_axis_acc_ready;
      m0_axis_res_ready = ~m0_axis_res_ready;
    end
    drive();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    s0_left = 0; s1_left = 0; s0_sent = 0; s1_sent = 0; res_left = 0;
    s0_lpos = FEED - 1; s1_lpos = FEED - 1;
    clear_logs();
    drive();
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_owner", int'(o_owner), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_acc_valid", int'(m_axis_acc_valid), 0);
    chk("rst_s0_ready", int'(s0_axis_ready), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_clk_e = 1'b1; s0_val = 8'sd1; toggle_rdy = 1'b0;
    m_axis_acc_ready = 1'b1; m0_axis_res_ready = 1'b1; m1_axis_res_ready = 1'b1;
    do_reset();

    // Single s0 job: 27 ones in, 9 threes back on m0.
    s0_left = FEED; drive();
    for (int i = 0; i < 300 && m0_rx < RES; i++) step();
    chk("t1_m0_rx", m0_rx, 9);
    chk("t1_m0_sum", m0_sum, 27);
    chk("t1_m0_last_idx", m0_last_idx, 9);
    chk("t1_acc_beats", acc_beats, 27);
    chk("t1_owner", owner_log.size() > 0 ? owner_log[0] : -1, 0);
    chk("t1_idle", int'(o_busy), 0);

    // Accumulator and m0 ready toggling every cycle.
    clear_logs(); s0_val = -8'sd5; toggle_rdy = 1'b1; s0_left = FEED; drive();
    for (int i = 0; i < 400 && m0_rx < RES; i++) step();
    toggle_rdy = 1'b0; m_axis_acc_ready = 1'b1; m0_axis_res_ready = 1'b1;
    chk("t2_acc_beats", acc_beats, 27);
    chk("t2_acc_lasts", acc_lasts, 1);
    chk("t2_last_beat", acc_last_beat, 27);
    chk("t2_m0_last_idx", m0_last_idx, 9);

    // Clock enable low for 5 cycles mid-FEED on an s1 job.
    clear_logs(); s1_left = FEED; drive();
    for (int i = 0; i < 100 && acc_beats < 10; i++) step();
    i_clk_e = 1'b0;
    repeat (5) step();
    chk("t3_frozen_beats", acc_beats, 10);
    i_clk_e = 1'b1;
    for (int i = 0; i < 300 && m1_rx < RES; i++) step();
    chk("t3_acc_beats", acc_beats, 27);
    chk("t3_last_beat", acc_last_beat, 27);
    chk("t3_m1_sum", m1_sum, 27);
    chk("t3_owner", owner_log.size() > 0 ? owner_log[0] : -1, 1);

    // Both requesting from reset: s0, s1, then s0 again.
    do_reset();
    s0_val = 8'sd7; s0_left = 2 * FEED; s1_left = FEED; drive();
    for (int i = 0; i < 900 && (m0_rx < 2 * RES || m1_rx < RES); i++) step();
    chk("t4_jobs", owner_log.size(), 3);
    chk("t4_job0", owner_log.size() > 0 ? owner_log[0] : -1, 0);
    chk("t4_job1", owner_log.size() > 1 ? owner_log[1] : -1, 1);
    chk("t4_job2", owner_log.size() > 2 ? owner_log[2] : -1, 0);

    // Reset at feed beat 13 discards the job; next job counts from beat 0.
    clear_logs(); s0_left = FEED; drive();
    for (int i = 0; i < 100 && acc_beats < 13; i++) step();
    chk("t5_reached13", acc_beats, 13);
    do_reset();
    s1_left = FEED; drive();
    for (int i = 0; i < 300 && m1_rx < RES; i++) step();
    chk("t5_acc_beats", acc_beats, 27);
    chk("t5_last_beat", acc_last_beat, 27);
    chk("t5_owner", owner_log.size() > 0 ? owner_log[0] : -1, 1);

    // s1 flags last on beat 10: framing error only when the check is built in.
    clear_logs(); s1_lpos = 9; s1_left = FEED; drive();
    for (int i = 0; i < 300 && m1_rx < RES; i++) step();
    chk("t6_acc_beats", acc_beats, 27);
    chk("t6_m1_rx", m1_rx, 9);
`ifdef MAT_ACCUM_ARB_ERR_EN
    chk("t6_err", int'(o_err), 1);
`else
    chk("t6_err", int'(o_err), 0);
`endif
    do_reset();
    chk("t6_err_cleared", int'(o_err), 0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mat_accum_arb.md
MAT_ACCUM_ARB -- requirements
Module: mat_accum_arb

Interface
REQ-001 Parameter FEED_BEATS, default 27: beats per job sent to the accumulator (three 3x3 matrices of 9 elements).
REQ-002 Parameter RES_BEATS, default 9: result beats per job returned by the accumulator.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_clk_e, input, 1: clock enable; state advances only when it is 1.
REQ-005 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Ports s0_axis_{data,valid,ready,last}, in/in/out/in, 8s/1/1/1: requester 0 operand stream.
REQ-007 Ports s1_axis_{data,valid,ready,last}, in/in/out/in, 8s/1/1/1: requester 1 operand stream.
REQ-008 Ports m_axis_acc_{data,valid,ready,last}, out/out/in/out, 8s/1/1/1: operand stream to the accumulator.
REQ-009 Ports s_axis_res_{data,valid,ready,last}, in/in/out/in, 8s/1/1/1: result stream from the accumulator.
REQ-010 Ports m0_axis_res_{data,valid,ready,last} and m1_axis_res_{data,valid,ready,last}, out/out/in/out, 8s/1/1/1: result streams returned to requester 0 and requester 1.
REQ-011 Port o_owner, output, 1: index of the requester currently granted; valid only when o_busy is 1.
REQ-012 Port o_busy, output, 1: 1 in FEED and DRAIN.
REQ-013 Port o_err, output, 1: sticky framing error (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, FEED and DRAIN.
REQ-015 IDLE: on an enabled edge with any sN_axis_valid=1, the FSM SHALL latch the owner and enter FEED; it SHALL NOT transfer data in that cycle (one-cycle grant latency).
REQ-016 Simultaneous requests SHALL be resolved round-robin: the pointer resets to 0, and after each job completes it points to the requester that did not own that job.
REQ-017 FEED datapath: m_axis_acc_data SHALL equal the owner's data, combinationally.
REQ-018 FEED handshake: m_axis_acc_valid = owner valid & i_clk_e, and owner ready = m_axis_acc_ready & i_clk_e; the non-owner's ready SHALL be 0.
REQ-019 A beat SHALL be counted when valid, ready and i_clk_e are all 1.
REQ-020 m_axis_acc_last SHALL be 1 exactly on feed beat FEED_BEATS-1, independent of the requester's last.
REQ-021 After the FEED_BEATS-th beat, the FSM SHALL enter DRAIN.
REQ-022 DRAIN: s_axis_res SHALL route combinationally to the owner's mN_axis_res, with ready and valid gated by i_clk_e.
REQ-023 DRAIN: the other requester's mN_axis_res_valid SHALL be 0.
REQ-024 mN_axis_res_last SHALL be generated internally on result beat RES_BEATS-1.
REQ-025 After the RES_BEATS-th result beat, the FSM SHALL return to IDLE and the round-robin pointer SHALL toggle away from the owner.
REQ-026 Outside DRAIN, s_axis_res_ready SHALL be 0.
REQ-027 In IDLE, every ready and valid output SHALL be 0.
REQ-028 Beat counters SHALL be 5 bits, clear on every state entry, and never wrap mid-job.
REQ-029 A stalled handshake (valid=1, ready=0) SHALL hold the counters; a requester dropping valid mid-job SHALL NOT lose the grant.
REQ-030 When i_clk_e=0, all state, counters and the pointer SHALL hold.

Reset
REQ-031 Reset, including reset asserted mid-job, SHALL immediately force: state IDLE, counters 0, pointer 0, o_owner 0, o_busy 0, o_err 0, all valid/ready/last outputs 0; any partial job is discarded.

Configuration
REQ-032 Macro MAT_ACCUM_ARB_ERR_EN, when defined, SHALL set o_err on a counted feed beat whose owner last disagrees with (beat == FEED_BEATS-1); o_err stays set until reset.
REQ-033 When MAT_ACCUM_ARB_ERR_EN is undefined, o_err SHALL be tied to 0 and the requester last inputs SHALL be ignored.

Verification
REQ-034 Reset, then s0 sends 27 beats of value 1 with ready=1 and the accumulator returns 9 beats of 3 -> m0 receives 9 beats of 3, last on the 9th, o_owner=0, FSM back in IDLE.
REQ-035 s0 and s1 both valid from reset -> s0 is served first, s1 second, then s0 again if still requesting.
REQ-036 m_axis_acc_ready toggling 1/0 each cycle during FEED -> exactly 27 beats are forwarded, with m_axis_acc_last only on the 27th.
REQ-037 i_clk_e low for 5 cycles mid-FEED -> no beats are counted and the counter is unchanged when i_clk_e returns high.
REQ-038 i_rst_n pulsed low at feed beat 13 -> all outputs return to 0 and the next job starts counting at beat 0.
REQ-039 With MAT_ACCUM_ARB_ERR_EN defined, s1_axis_last asserted on beat 10 -> o_err=1 from the next edge until reset, and the job still completes with 27 beats.
